// File: rtl/multi_cycle_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state codes, RV32I opcodes,
// ALU operation classes, write-back source codes and the registered control bundle.
package multi_cycle_pkg;

  // FSM state codes, kept as plain constants so older tooling can consume them.
  typedef logic [2:0] state_t;
  localparam state_t StFetch  = 3'd0;
  localparam state_t StDecode = 3'd1;
  localparam state_t StExec   = 3'd2;
  localparam state_t StMdWait = 3'd3;
  localparam state_t StMem    = 3'd4;
  localparam state_t StWb     = 3'd5;
  localparam state_t StTrap   = 3'd6;

  // RV32I major opcodes.
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpIalu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [6:0] Funct7Mext = 7'b0000001;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  // ALU operation classes; the ALU decoder refines them with Funct3/Funct7.
  localparam logic [2:0] AluAdd    = 3'd0;
  localparam logic [2:0] AluRtype  = 3'd1;
  localparam logic [2:0] AluItype  = 3'd2;
  localparam logic [2:0] AluBranch = 3'd3;
  localparam logic [2:0] AluPassB  = 3'd4;

  // Write-back source select.
  localparam logic [1:0] SrcAlu = 2'b00;
  localparam logic [1:0] SrcMem = 2'b01;
  localparam logic [1:0] SrcPc4 = 2'b10;
  localparam logic [1:0] SrcMd  = 2'b11;

  // Registered control outputs, one field per datapath strobe or select.
  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       mem_wr_en;
    logic [1:0] src_to_reg;
    logic       reg_wr_en;
    logic       alu_src1_sel;
    logic       alu_src2_sel;
    logic       sub;
    logic       en_pc;
    logic       branch;
    logic       jump;
    logic       md_start;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  function automatic logic opcode_known(input logic [6:0] opcode);
    case (opcode)
      OpRtype, OpIalu, OpLoad, OpStore, OpBranch,
      OpJal, OpJalr, OpLui, OpAuipc: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // ALU operand selects and operation class for an instruction class.
  function automatic ctrl_t alu_setup(input logic [6:0] opcode, input logic [6:0] funct7,
                                      input logic [2:0] funct3);
    ctrl_t c;
    c = '0;
    case (opcode)
      OpRtype: begin
        c.alu_ctrl = AluRtype;
        // Only SUB (funct3 000) and SRA (funct3 101) use the alternate funct7.
        c.sub      = (funct7 == Funct7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101));
      end
      OpIalu: begin
        c.alu_src2_sel = 1'b1;
        c.alu_ctrl     = AluItype;
      end
      OpLoad, OpStore, OpJalr: begin
        c.alu_src2_sel = 1'b1;
        c.alu_ctrl     = AluAdd;
      end
      OpBranch: begin
        c.alu_ctrl = AluBranch;
        c.sub      = 1'b1;
      end
      OpJal, OpAuipc: begin
        c.alu_src1_sel = 1'b1;
        c.alu_src2_sel = 1'b1;
        c.alu_ctrl     = AluAdd;
      end
      OpLui: begin
        c.alu_src2_sel = 1'b1;
        c.alu_ctrl     = AluPassB;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter timing the multiply/divide unit: loads MD_LATENCY-1, then counts to zero.
module md_latency_counter #(
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic CLK,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int unsigned CntW = $clog2(MD_LATENCY + 1);

  logic [CntW-1:0] count_q, count_d;

  // Next count: load wins over decrement; saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = CntW'(MD_LATENCY - 1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I(+M) control FSM: fetch/decode/execute/memory/write-back sequencing
// with handshaked instruction and data memories. Controls are registered per state.
module multi_cycle_ctrl
  import multi_cycle_pkg::*;
#(
  parameter int unsigned ALU_DECODER_IN = 3,
  parameter bit          M_EXT          = 1'b1,
  parameter int unsigned MD_LATENCY     = 32
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic [6:0]                Opcode,
  input  logic [6:0]                Funct7,
  input  logic [2:0]                Funct3,
  input  logic                      IMEM_Ack,
  input  logic                      DMEM_Ack,
  output logic                      IMEM_Req,
  output logic                      IR_Wr,
  output logic                      DMEM_Req,
  output logic                      MEM_Wr_En,
  output logic [1:0]                Src_to_Reg,
  output logic                      Reg_Wr_En,
  output logic                      ALU_Src1_Sel,
  output logic                      ALU_Src2_Sel,
  output logic                      Sub,
  output logic                      EN_PC,
  output logic                      Branch,
  output logic                      Jump,
  output logic                      MD_Start,
  output logic [ALU_DECODER_IN-1:0] ALU_Ctrl,
  output logic                      Illegal_Instr
);

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  logic   md_done;

  md_latency_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_cnt (
    .CLK (CLK),
    .rst (rst),
    .load(ctrl_q.md_start),
    .dec (state_q == StMdWait),
    .done(md_done)
  );

  // Next state and next registered controls for the state being entered.
  always_comb begin
    logic is_md, is_mem, is_store, is_jump, is_legal;

    is_md    = (Opcode == OpRtype) && (Funct7 == Funct7Mext);
    is_mem   = (Opcode == OpLoad) || (Opcode == OpStore);
    is_store = (Opcode == OpStore);
    is_jump  = (Opcode == OpJal) || (Opcode == OpJalr);
    is_legal = opcode_known(Opcode) && (M_EXT || !is_md);

    state_d   = state_q;
    ctrl_d    = '0;
    illegal_d = illegal_q;

    unique case (state_q)
      StFetch: begin
        // Req is registered, so the first cycle after reset idles with Req low.
        if (ctrl_q.imem_req && IMEM_Ack) begin
          state_d = StDecode;
        end else begin
          ctrl_d.imem_req = 1'b1;
        end
      end
      StDecode: begin
        if (!is_legal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d         = StExec;
          ctrl_d          = alu_setup(Opcode, Funct7, Funct3);
          ctrl_d.branch   = (Opcode == OpBranch);
          ctrl_d.en_pc    = (Opcode == OpBranch);
          ctrl_d.jump     = is_jump;
          ctrl_d.md_start = M_EXT && is_md;
        end
      end
      StExec: begin
        if (Opcode == OpBranch) begin
          state_d         = StFetch;
          ctrl_d.imem_req = 1'b1;
        end else if (is_mem) begin
          state_d          = StMem;
          // Hold the address computation for the whole memory access.
          ctrl_d           = alu_setup(Opcode, Funct7, Funct3);
          ctrl_d.dmem_req  = 1'b1;
          ctrl_d.mem_wr_en = is_store;
        end else if (M_EXT && is_md) begin
          state_d = StMdWait;
        end else begin
          state_d           = StWb;
          ctrl_d.reg_wr_en  = 1'b1;
          ctrl_d.en_pc      = 1'b1;
          ctrl_d.src_to_reg = is_jump ? SrcPc4 : SrcAlu;
        end
      end
      StMdWait: begin
        if (md_done) begin
          state_d           = StWb;
          ctrl_d.reg_wr_en  = 1'b1;
          ctrl_d.en_pc      = 1'b1;
          ctrl_d.src_to_reg = SrcMd;
        end
      end
      StMem: begin
        if (ctrl_q.dmem_req && DMEM_Ack) begin
          if (is_store) begin
            // The store already strobed EN_PC on its ack cycle.
            state_d         = StFetch;
            ctrl_d.imem_req = 1'b1;
          end else begin
            state_d           = StWb;
            ctrl_d.reg_wr_en  = 1'b1;
            ctrl_d.en_pc      = 1'b1;
            ctrl_d.src_to_reg = SrcMem;
          end
        end else begin
          ctrl_d           = alu_setup(Opcode, Funct7, Funct3);
          ctrl_d.dmem_req  = 1'b1;
          ctrl_d.mem_wr_en = is_store;
        end
      end
      StWb: begin
        state_d         = StFetch;
        ctrl_d.imem_req = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State, control and sticky illegal flag registers; reset aborts any access.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= StFetch;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign IMEM_Req      = ctrl_q.imem_req;
  // IR load must coincide with the data-valid cycle, so it is the ack qualified by Req.
  assign IR_Wr         = ctrl_q.imem_req & IMEM_Ack;
  assign DMEM_Req      = ctrl_q.dmem_req;
  assign MEM_Wr_En     = ctrl_q.mem_wr_en;
  assign Src_to_Reg    = ctrl_q.src_to_reg;
  assign Reg_Wr_En     = ctrl_q.reg_wr_en;
  assign ALU_Src1_Sel  = ctrl_q.alu_src1_sel;
  assign ALU_Src2_Sel  = ctrl_q.alu_src2_sel;
  assign Sub           = ctrl_q.sub;
  // A store retires on its ack cycle; every other PC strobe is registered.
  assign EN_PC         = ctrl_q.en_pc | (ctrl_q.dmem_req & ctrl_q.mem_wr_en & DMEM_Ack);
  assign Branch        = ctrl_q.branch;
  assign Jump          = ctrl_q.jump;
  assign MD_Start      = ctrl_q.md_start;
  assign ALU_Ctrl      = ALU_DECODER_IN'(ctrl_q.alu_ctrl);
  assign Illegal_Instr = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: one M_EXT=1 instance under test plus an M_EXT=0
// instance sharing the stimulus to observe the illegal-MUL path.
module tb_multi_cycle_ctrl;
  import multi_cycle_pkg::*;

  logic       CLK = 1'b0;
  logic       rst;
  logic [6:0] Opcode, Funct7;
  logic [2:0] Funct3;
  logic       IMEM_Ack, DMEM_Ack;

  logic       IMEM_Req, IR_Wr, DMEM_Req, MEM_Wr_En, Reg_Wr_En, ALU_Src1_Sel, ALU_Src2_Sel;
  logic       Sub, EN_PC, Branch, Jump, MD_Start, Illegal_Instr;
  logic [1:0] Src_to_Reg;
  logic [2:0] ALU_Ctrl;

  logic       n_IMEM_Req, n_IR_Wr, n_DMEM_Req, n_MEM_Wr_En, n_Reg_Wr_En, n_ALU_Src1_Sel;
  logic       n_ALU_Src2_Sel, n_Sub, n_EN_PC, n_Branch, n_Jump, n_MD_Start, n_Illegal_Instr;
  logic [1:0] n_Src_to_Reg;
  logic [2:0] n_ALU_Ctrl;

  logic [17:0] outs, n_outs;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned req_cnt;

  always #5 CLK = ~CLK;

  multi_cycle_ctrl #(
    .ALU_DECODER_IN(3),
    .M_EXT         (1'b1),
    .MD_LATENCY    (4)
  ) u_dut (
    .CLK(CLK), .rst(rst), .Opcode(Opcode), .Funct7(Funct7), .Funct3(Funct3),
    .IMEM_Ack(IMEM_Ack), .DMEM_Ack(DMEM_Ack), .IMEM_Req(IMEM_Req), .IR_Wr(IR_Wr),
    .DMEM_Req(DMEM_Req), .MEM_Wr_En(MEM_Wr_En), .Src_to_Reg(Src_to_Reg),
    .Reg_Wr_En(Reg_Wr_En), .ALU_Src1_Sel(ALU_Src1_Sel), .ALU_Src2_Sel(ALU_Src2_Sel),
    .Sub(Sub), .EN_PC(EN_PC), .Branch(Branch), .Jump(Jump), .MD_Start(MD_Start),
    .ALU_Ctrl(ALU_Ctrl), .Illegal_Instr(Illegal_Instr)
  );

  multi_cycle_ctrl #(
    .ALU_DECODER_IN(3),
    .M_EXT         (1'b0),
    .MD_LATENCY    (4)
  ) u_dut_nom (
    .CLK(CLK), .rst(rst), .Opcode(Opcode), .Funct7(Funct7), .Funct3(Funct3),
    .IMEM_Ack(IMEM_Ack), .DMEM_Ack(DMEM_Ack), .IMEM_Req(n_IMEM_Req), .IR_Wr(n_IR_Wr),
    .DMEM_Req(n_DMEM_Req), .MEM_Wr_En(n_MEM_Wr_En), .Src_to_Reg(n_Src_to_Reg),
    .Reg_Wr_En(n_Reg_Wr_En), .ALU_Src1_Sel(n_ALU_Src1_Sel), .ALU_Src2_Sel(n_ALU_Src2_Sel),
    .Sub(n_Sub), .EN_PC(n_EN_PC), .Branch(n_Branch), .Jump(n_Jump), .MD_Start(n_MD_Start),
    .ALU_Ctrl(n_ALU_Ctrl), .Illegal_Instr(n_Illegal_Instr)
  );

  assign outs = {IMEM_Req, IR_Wr, DMEM_Req, MEM_Wr_En, Src_to_Reg, Reg_Wr_En, ALU_Src1_Sel,
                 ALU_Src2_Sel, Sub, EN_PC, Branch, Jump, MD_Start, ALU_Ctrl, Illegal_Instr};
  assign n_outs = {n_IMEM_Req, n_IR_Wr, n_DMEM_Req, n_MEM_Wr_En, n_Src_to_Reg, n_Reg_Wr_En,
                   n_ALU_Src1_Sel, n_ALU_Src2_Sel, n_Sub, n_EN_PC, n_Branch, n_Jump,
                   n_MD_Start, n_ALU_Ctrl, n_Illegal_Instr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_sample();
    @(negedge CLK);
  endtask

  // Called at posedge+1; returns at posedge+1 of the DECODE cycle.
  task automatic fetch(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input int unsigned wait_cyc);
    int unsigned guard;
    guard    = 0;
    Opcode   = op;
    Funct7   = f7;
    Funct3   = f3;
    IMEM_Ack = 1'b0;
    at_sample();
    while ((IMEM_Req !== 1'b1) && (guard < 8)) begin
      step();
      at_sample();
      guard++;
    end
    check("fetch_req_seen", IMEM_Req, 1);
    for (int i = 0; i < int'(wait_cyc); i++) begin
      check("fetch_wait", {IMEM_Req, IR_Wr}, 2'b10);
      step();
      at_sample();
    end
    IMEM_Ack = 1'b1;
    #1;
    check("ir_wr_on_ack", {IMEM_Req, IR_Wr}, 2'b11);
    step();
    IMEM_Ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    Opcode   = '0;
    Funct7   = '0;
    Funct3   = '0;
    IMEM_Ack = 1'b0;
    DMEM_Ack = 1'b0;
    step();
    step();
    at_sample();
    check("reset_outs", outs, 0);
    check("reset_outs_nom", n_outs, 0);
    step();
    rst      = 1'b0;
    IMEM_Ack = 1'b1;
    at_sample();
    check("idle_req_after_reset", IMEM_Req, 0);
    check("stray_ack_ignored", IR_Wr, 0);
    step();
    IMEM_Ack = 1'b0;

    // LOAD aborted by reset in MEM; the late DMEM_Ack must be ignored.
    fetch(OpLoad, 7'd0, 3'b010, 0);
    at_sample();
    check("ld_decode_idle", {DMEM_Req, Reg_Wr_En, EN_PC}, 0);
    step();
    at_sample();
    check("ld_exec_src2", {ALU_Src2_Sel, DMEM_Req}, 2'b10);
    step();
    at_sample();
    check("ld_mem_req", DMEM_Req, 1);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    DMEM_Ack = 1'b1;
    at_sample();
    check("rst_mid_mem_outs", outs, 0);
    step();
    DMEM_Ack = 1'b0;
    at_sample();
    check("post_rst_fetch", {IMEM_Req, DMEM_Req, Reg_Wr_En, EN_PC}, 4'b1000);
    step();

    // ADD, zero-wait.
    fetch(OpRtype, 7'd0, 3'b000, 0);
    at_sample();
    check("add_decode", {Reg_Wr_En, EN_PC, IMEM_Req}, 0);
    step();
    at_sample();
    check("add_exec_sel", {ALU_Src1_Sel, ALU_Src2_Sel, Sub, Reg_Wr_En}, 0);
    check("add_exec_ctrl", ALU_Ctrl, AluRtype);
    step();
    at_sample();
    check("add_wb", {Reg_Wr_En, EN_PC, Src_to_Reg}, 4'b1100);
    step();
    at_sample();
    check("add_next_fetch", {IMEM_Req, Reg_Wr_En, EN_PC}, 3'b100);
    step();

    // SUB with two IMEM wait cycles.
    fetch(OpRtype, Funct7Alt, 3'b000, 2);
    step();
    at_sample();
    check("sub_exec", Sub, 1);
    step();
    at_sample();
    check("sub_wb", {Reg_Wr_En, EN_PC}, 2'b11);
    step();

    // LOAD with DMEM_Ack three cycles late.
    fetch(OpLoad, 7'd0, 3'b010, 0);
    step();
    step();
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      at_sample();
      if (DMEM_Req === 1'b1) req_cnt++;
      check("ld_wait_no_wb", {Reg_Wr_En, EN_PC}, 0);
      step();
    end
    at_sample();
    DMEM_Ack = 1'b1;
    #1;
    if (DMEM_Req === 1'b1) req_cnt++;
    check("ld_ack_no_enpc", {EN_PC, MEM_Wr_En}, 0);
    step();
    DMEM_Ack = 1'b0;
    at_sample();
    check("ld_req_cycles", req_cnt, 4);
    check("ld_req_dropped", DMEM_Req, 0);
    check("ld_wb", {Reg_Wr_En, EN_PC, Src_to_Reg}, 4'b1101);
    step();

    // STORE, zero-wait: EN_PC on the ack cycle, no write-back.
    fetch(OpStore, 7'd0, 3'b010, 0);
    step();
    step();
    at_sample();
    DMEM_Ack = 1'b1;
    #1;
    check("st_mem", {DMEM_Req, MEM_Wr_En, EN_PC, Reg_Wr_En}, 4'b1110);
    step();
    DMEM_Ack = 1'b0;
    at_sample();
    check("st_done", {IMEM_Req, DMEM_Req, MEM_Wr_En, EN_PC}, 4'b1000);
    step();

    // BEQ: branch, compare and PC strobe together in EXEC.
    fetch(OpBranch, 7'd0, 3'b000, 0);
    step();
    at_sample();
    check("beq_exec", {Branch, Sub, EN_PC, Reg_Wr_En}, 4'b1110);
    step();
    at_sample();
    check("beq_next", {IMEM_Req, Branch, EN_PC, Reg_Wr_En}, 4'b1000);
    step();

    // JAL: jump in EXEC, PC+4 written back.
    fetch(OpJal, 7'd0, 3'b000, 0);
    step();
    at_sample();
    check("jal_exec", {Jump, ALU_Src1_Sel, ALU_Src2_Sel, EN_PC}, 4'b1110);
    step();
    at_sample();
    check("jal_wb", {Reg_Wr_En, EN_PC, Jump, Src_to_Reg}, 5'b11010);
    step();

    // MUL with MD_LATENCY = 4; the M_EXT=0 instance traps on it.
    fetch(OpRtype, Funct7Mext, 3'b000, 0);
    step();
    at_sample();
    check("mul_start", MD_Start, 1);
    check("mul_nom_trap", n_Illegal_Instr, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      at_sample();
      check("mul_wait", {MD_Start, Reg_Wr_En, EN_PC}, 0);
      step();
    end
    at_sample();
    check("mul_wb", {Reg_Wr_En, EN_PC, Src_to_Reg}, 4'b1111);
    check("mul_legal", Illegal_Instr, 0);
    step();

    // Unknown opcode: trap holds, reset clears.
    fetch(7'b1111111, 7'd0, 3'b000, 0);
    step();
    for (int i = 0; i < 20; i++) begin
      at_sample();
      check("trap_hold", {Illegal_Instr, EN_PC, IMEM_Req, Reg_Wr_En}, 4'b1000);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_sample();
    check("trap_cleared", {Illegal_Instr, n_Illegal_Instr}, 0);
    check("trap_cleared_outs", outs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
